// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core.
// Holds the FSM state encoding, the supported opcode/funct values, the bit
// positions of the instruction fields and the immediate sign-extension helper.
package mips_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int JT_HI  = 7;
  localparam int JT_LO  = 0;

  localparam logic [4:0] LINK_REG = 5'd31;

  // The helper extends to a fixed wide value; callers size-cast it down to
  // their data width, which also gives the truncation wanted for narrow words.
  localparam int SEXT_W = 64;

  function automatic logic [SEXT_W-1:0] sign_extend16(input logic [15:0] v);
    return {{(SEXT_W-16){v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32-entry register file for the MIPS-subset core.
// Ports: clk/rst_n (async active-low clear), clear (synchronous clear of all
// entries), we/waddr/wdata (one synchronous write port), raddr_a/raddr_b with
// rdata_a/rdata_b (two combinational read ports), tap_rdata (combinational view
// of register TAP_REG, used to capture the result on halt).
// Register 0 is never written and always reads as zero.
module mips_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TAP_REG = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [4:0]        raddr_a,
  input  logic [4:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] tap_rdata
);

  localparam logic [4:0] TAP = 5'(TAP_REG);

  logic [DATA_W-1:0] regs [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a   = (raddr_a == 5'd0) ? '0 : regs[raddr_a];
  assign rdata_b   = (raddr_b == 5'd0) ? '0 : regs[raddr_b];
  assign tap_rdata = (TAP == 5'd0)     ? '0 : regs[TAP];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset processor: every instruction passes through
// FETCH, DECODE, EXEC, MEM and WB (five cycles), then the core fetches again
// or halts.
// Ports: clk, rst_n (async active-low); start (run from pc 0, honoured in
// IDLE/HALT); imem_we/imem_addr/imem_wdata (program load); dmem_we/dmem_addr/
// dmem_wdata (data load) with dmem_rdata (combinational readback at
// dmem_addr); busy (FETCH..WB), done (HALT), fault (sticky error flag),
// pc (current instruction index), result (register RESULT_REG captured on
// entry to HALT).
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 16,
  parameter int RESULT_REG = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  input  logic [31:0]                   imem_wdata,
  input  logic                          dmem_we,
  input  logic [$clog2(DMEM_DEPTH)-1:0] dmem_addr,
  input  logic [DATA_W-1:0]             dmem_wdata,
  output logic [DATA_W-1:0]             dmem_rdata,
  output logic                          busy,
  output logic                          done,
  output logic                          fault,
  output logic [7:0]                    pc,
  output logic [DATA_W-1:0]             result
);

  localparam int IA_W = $clog2(IMEM_DEPTH);
  localparam int DA_W = $clog2(DMEM_DEPTH);
  localparam logic [4:0] RES_IDX = 5'(RESULT_REG);

  state_t            state, next_state;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a, b, alu_out, mdr;
  logic [7:0]        npc;

  logic [31:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];

  logic [5:0]        op, funct;
  logic [4:0]        rs, rt, rd;
  logic [15:0]       imm16;
  logic [DATA_W-1:0] imm_ext;
  logic [7:0]        jtarget;

  logic              is_alu_r, is_jr, is_load, is_store, is_valid;
  logic              mem_oob, pc_oob, start_ok, enter_halt;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata, rf_rdata_a, rf_rdata_b, rf_tap, result_next;

  assign op      = ir[OP_HI:OP_LO];
  assign rs      = ir[RS_HI:RS_LO];
  assign rt      = ir[RT_HI:RT_LO];
  assign rd      = ir[RD_HI:RD_LO];
  assign funct   = ir[FN_HI:FN_LO];
  assign imm16   = ir[IMM_HI:IMM_LO];
  assign jtarget = ir[JT_HI:JT_LO];
  assign imm_ext = DATA_W'(sign_extend16(imm16));

  // Instruction classification from the latched instruction word. Anything
  // not recognised here is reported as a fault at the end of EXEC.
  always_comb begin
    is_alu_r = (op == OP_RTYPE) &&
               ((funct == FN_ADDU) || (funct == FN_SUBU) || (funct == FN_SLT));
    is_jr    = (op == OP_RTYPE) && (funct == FN_JR);
    is_load  = (op == OP_LW);
    is_store = (op == OP_SW);
    is_valid = is_alu_r || is_jr || is_load || is_store ||
               (op == OP_J) || (op == OP_JAL) || (op == OP_BEQ) ||
               (op == OP_BNE) || (op == OP_ADDIU);
  end

  // Depths are powers of two, so "address beyond the memory" is simply any
  // set bit above the index width.
  assign mem_oob  = (is_load || is_store) && ((alu_out >> DA_W) != '0);
  assign pc_oob   = ((npc >> IA_W) != 8'd0);
  assign start_ok = start && ((state == S_IDLE) || (state == S_HALT));

  // Write-back selection: R-type ALU results go to rd, jal links into r31,
  // addiu and lw write rt.
  always_comb begin
    rf_we    = (state == S_WB) &&
               (is_load || is_alu_r || (op == OP_ADDIU) || (op == OP_JAL));
    rf_waddr = rt;
    if (is_alu_r)          rf_waddr = rd;
    else if (op == OP_JAL) rf_waddr = LINK_REG;
    rf_wdata = is_load ? mdr : alu_out;
  end

  mips_regfile #(
    .DATA_W  (DATA_W),
    .TAP_REG (RESULT_REG)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_ok),
    .we        (rf_we),
    .waddr     (rf_waddr),
    .wdata     (rf_wdata),
    .raddr_a   (rs),
    .raddr_b   (rt),
    .rdata_a   (rf_rdata_a),
    .rdata_b   (rf_rdata_b),
    .tap_rdata (rf_tap)
  );

  // The result register is captured on the same edge that may write back the
  // last instruction, so a write to RESULT_REG is forwarded around the file.
  assign result_next = (rf_we && (rf_waddr == RES_IDX) && (RES_IDX != 5'd0))
                       ? rf_wdata : rf_tap;
  assign enter_halt  = (next_state == S_HALT) && (state != S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE:   if (start) next_state = S_FETCH;
      S_FETCH:  begin busy = 1'b1; next_state = S_DECODE; end
      S_DECODE: begin busy = 1'b1; next_state = S_EXEC; end
      S_EXEC:   begin busy = 1'b1; next_state = is_valid ? S_MEM : S_HALT; end
      S_MEM:    begin busy = 1'b1; next_state = mem_oob ? S_HALT : S_WB; end
      S_WB:     begin busy = 1'b1; next_state = pc_oob ? S_HALT : S_FETCH; end
      S_HALT:   begin done = 1'b1; if (start) next_state = S_FETCH; end
      default:  next_state = S_IDLE;
    endcase
  end

  // Datapath registers. The pc only changes in WB; faulting instructions
  // leave it pointing at themselves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= 8'd0;
      ir      <= 32'd0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      npc     <= 8'd0;
      result  <= '0;
      fault   <= 1'b0;
    end else begin
      if (enter_halt) result <= result_next;
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc    <= 8'd0;
            fault <= 1'b0;
          end
        end
        S_FETCH:  ir <= imem[pc[IA_W-1:0]];
        S_DECODE: begin
          a <= rf_rdata_a;
          b <= rf_rdata_b;
        end
        S_EXEC: begin
          npc <= pc + 8'd1;
          case (op)
            OP_RTYPE: begin
              case (funct)
                FN_ADDU: alu_out <= a + b;
                FN_SUBU: alu_out <= a - b;
                FN_SLT:  alu_out <= ($signed(a) < $signed(b)) ? DATA_W'(1) : '0;
                FN_JR:   npc     <= a[7:0];
                default: fault   <= 1'b1;
              endcase
            end
            OP_J:   npc <= jtarget;
            OP_JAL: begin
              npc     <= jtarget;
              alu_out <= DATA_W'(pc + 8'd1);
            end
            OP_BEQ: if (a == b) npc <= pc + 8'd1 + imm16[7:0];
            OP_BNE: if (a != b) npc <= pc + 8'd1 + imm16[7:0];
            OP_ADDIU, OP_LW, OP_SW: alu_out <= a + imm_ext;
            default: fault <= 1'b1;
          endcase
        end
        S_MEM: begin
          if (mem_oob)      fault <= 1'b1;
          else if (is_load) mdr   <= dmem[alu_out[DA_W-1:0]];
        end
        S_WB:    pc <= npc;
        default: ;
      endcase
    end
  end

  // Memories are not reset. External loads are accepted only while the core
  // is not running, so they can never collide with an internal store.
  always_ff @(posedge clk) begin
    if (imem_we && !busy) imem[imem_addr] <= imem_wdata;
    if (dmem_we && !busy)
      dmem[dmem_addr] <= dmem_wdata;
    else if ((state == S_MEM) && is_store && !mem_oob)
      dmem[alu_out[DA_W-1:0]] <= b;
  end

  assign dmem_rdata = dmem[dmem_addr];

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench for mips_multicycle_core (DATA_W=8, 16-word memories,
// result from r2). An instruction-level interpreter predicts the halt state
// of every program; predictions go into a queue that a monitor compares
// when the core raises done. Data memory is read back after each run.
module tb_mips_multicycle_core;

  localparam int DW = 8;
  localparam int ID = 16;
  localparam int DD = 16;
  localparam int DMASK = 255;

  typedef struct {
    logic [7:0] result;
    logic [7:0] pc;
    logic       fault;
    int         cycles;
  } exp_t;

  logic          clk, rst_n, start, imem_we, dmem_we;
  logic [3:0]    imem_addr, dmem_addr;
  logic [31:0]   imem_wdata;
  logic [DW-1:0] dmem_wdata, dmem_rdata, result;
  logic          busy, done, fault;
  logic [7:0]    pc;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  logic [31:0] m_imem [ID];
  int          m_dmem [DD];

  mips_multicycle_core #(
    .DATA_W(DW), .IMEM_DEPTH(ID), .DMEM_DEPTH(DD), .RESULT_REG(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .busy(busy), .done(done), .fault(fault),
    .pc(pc), .result(result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_j(input int op, input int tgt);
    return {6'(op), 26'(tgt)};
  endfunction

  function automatic int to_signed8(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Instruction-level interpreter: each instruction costs five cycles, except
  // an illegal one (halts after EXEC, three) or an out-of-range data access
  // (halts after MEM, four).
  task automatic run_model(output exp_t e);
    int r[32];
    int pcv, cyc, op, rs, rt, rd, fn, imm, av, bv, npc, wr, wv, addr;
    logic [31:0] w;
    bit stop;
    for (int i = 0; i < 32; i++) r[i] = 0;
    pcv = 0; cyc = 0; stop = 0;
    e.fault = 1'b0;
    for (int n = 0; n < 500 && !stop; n++) begin
      w   = m_imem[pcv];
      op  = int'(w[31:26]); rs = int'(w[25:21]); rt = int'(w[20:16]);
      rd  = int'(w[15:11]); fn = int'(w[5:0]);
      imm = int'($signed(w[15:0]));
      av  = r[rs]; bv = r[rt];
      npc = (pcv + 1) & 255;
      wr  = -1; wv = 0;
      case (op)
        'h00: begin
          case (fn)
            'h08: npc = av & 255;
            'h21: begin wr = rd; wv = (av + bv) & DMASK; end
            'h23: begin wr = rd; wv = (av - bv) & DMASK; end
            'h2A: begin wr = rd; wv = (to_signed8(av) < to_signed8(bv)) ? 1 : 0; end
            default: e.fault = 1'b1;
          endcase
        end
        'h02: npc = int'(w[7:0]);
        'h03: begin wr = 31; wv = (pcv + 1) & DMASK; npc = int'(w[7:0]); end
        'h04: if (av == bv) npc = (pcv + 1 + imm) & 255;
        'h05: if (av != bv) npc = (pcv + 1 + imm) & 255;
        'h09: begin wr = rt; wv = (av + imm) & DMASK; end
        'h23, 'h2B: begin
          addr = (av + imm) & DMASK;
          if (addr >= DD) begin
            e.fault = 1'b1;
            cyc += 1;
          end else if (op == 'h23) begin
            wr = rt; wv = m_dmem[addr];
          end else begin
            m_dmem[addr] = bv;
          end
        end
        default: e.fault = 1'b1;
      endcase
      if (e.fault) begin
        cyc += 3;
        stop = 1;
      end else begin
        cyc += 5;
        if (wr > 0) r[wr] = wv;
        pcv = npc;
        if (pcv >= ID) stop = 1;
      end
    end
    e.result = 8'(r[2]);
    e.pc     = 8'(pcv);
    e.cycles = cyc;
  endtask

  // Monitor: counts busy cycles and compares against the oldest prediction
  // each time done rises.
  initial begin
    logic done_q;
    int   busy_cnt;
    exp_t e;
    done_q = 1'b0;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (done && !done_q) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("halt_result", 32'(result), 32'(e.result));
          checkOutput("halt_pc", 32'(pc), 32'(e.pc));
          checkOutput("halt_fault", 32'(fault), 32'(e.fault));
          checkOutput("halt_cycles", 32'(busy_cnt), 32'(e.cycles));
        end
      end
      done_q = done;
      if (busy) busy_cnt++;
      else      busy_cnt = 0;
    end
  end

  task automatic fill_halt();
    for (int i = 0; i < ID; i++) m_imem[i] = enc_j('h02, 'hFF);
  endtask

  // Load both memories, predict, start the run (with a start pulse and a
  // junk data write during the first busy cycle, both of which must be
  // ignored), wait for done and read the whole data memory back.
  task automatic applyStimulus(input string tag);
    exp_t e;
    bit   got;
    for (int i = 0; i < ID; i++) begin
      @(negedge clk);
      imem_we = 1'b1; imem_addr = 4'(i); imem_wdata = m_imem[i];
      dmem_we = 1'b1; dmem_addr = 4'(i); dmem_wdata = 8'(m_dmem[i]);
    end
    @(negedge clk);
    imem_we = 1'b0; dmem_we = 1'b0;
    run_model(e);
    exp_q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    checkOutput({tag, "_fault_cleared"}, 32'(fault), 32'd0);
    dmem_we = 1'b1; dmem_addr = 4'($urandom_range(0, 15));
    dmem_wdata = 8'($urandom_range(0, 255));
    @(negedge clk);
    start = 1'b0; dmem_we = 1'b0;
    got = 0;
    for (int c = 0; c < 2000 && !got; c++) begin
      if (done) got = 1;
      else @(negedge clk);
    end
    if (!got) begin
      checkOutput({tag, "_done_timeout"}, 32'd0, 32'd1);
      exp_q.delete();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
    #1;
    for (int i = 0; i < DD; i++) begin
      dmem_addr = 4'(i);
      #1;
      checkOutput($sformatf("%s_dmem%0d", tag, i), 32'(dmem_rdata), 32'(m_dmem[i] & DMASK));
    end
  endtask

  task automatic random_program();
    int k;
    for (int i = 0; i < ID; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1: m_imem[i] = enc_i('h09, $urandom_range(0, 7), $urandom_range(1, 7), $urandom_range(0, 65535));
        2: m_imem[i] = enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(1, 7), 'h21);
        3: m_imem[i] = enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(1, 7), 'h23);
        4: m_imem[i] = enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(1, 7), 'h2A);
        5, 6: m_imem[i] = enc_i((k == 5) ? 'h23 : 'h2B,
                                ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7),
                                $urandom_range(1, 7), $urandom_range(0, 17));
        7: m_imem[i] = enc_i($urandom_range(4, 5), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
        8: m_imem[i] = enc_j('h02, i + $urandom_range(1, 4));
        default: m_imem[i] = ($urandom_range(0, 1) == 0) ? enc_j('h3F, 0) : enc_r(1, 2, 3, 'h00);
      endcase
    end
    for (int i = 0; i < DD; i++) m_dmem[i] = $urandom_range(0, 255);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; imem_we = 1'b0; dmem_we = 1'b0;
    imem_addr = '0; dmem_addr = '0; imem_wdata = '0; dmem_wdata = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_fault", 32'(fault), 32'd0);
    checkOutput("reset_pc", 32'(pc), 32'd0);
    checkOutput("reset_result", 32'(result), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < DD; i++) m_dmem[i] = 0;

    // addiu r2,r0,5 ; addiu r3,r0,-1 ; addu r2,r2,r3
    fill_halt();
    m_imem[0] = enc_i('h09, 0, 2, 5);
    m_imem[1] = enc_i('h09, 0, 3, -1);
    m_imem[2] = enc_r(2, 3, 2, 'h21);
    applyStimulus("arith");

    // Abort in EXEC of the first addiu, then rerun the same program.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_result", 32'(result), 32'd0);
    checkOutput("abort_pc", 32'(pc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("rerun");

    // Sum dmem[0..3] into r2 with a bne loop.
    fill_halt();
    m_dmem[0] = 1; m_dmem[1] = 2; m_dmem[2] = 3; m_dmem[3] = 4;
    m_imem[0] = enc_i('h09, 0, 4, 4);
    m_imem[1] = enc_i('h09, 0, 5, 0);
    m_imem[2] = enc_i('h23, 5, 6, 0);
    m_imem[3] = enc_r(2, 6, 2, 'h21);
    m_imem[4] = enc_i('h09, 5, 5, 1);
    m_imem[5] = enc_i('h05, 5, 4, -4);
    applyStimulus("sumloop");

    // Store 0x7F to dmem[5], then a load from address 20 that must fault.
    fill_halt();
    m_imem[0] = enc_i('h09, 0, 2, 'h7F);
    m_imem[1] = enc_i('h2B, 0, 2, 5);
    m_imem[2] = enc_i('h09, 0, 7, 20);
    m_imem[3] = enc_i('h23, 7, 3, 0);
    applyStimulus("store_oob");

    // jal to 6, jr r31 back, then slt -1 < 1.
    fill_halt();
    m_imem[0] = enc_i('h09, 0, 3, -1);
    m_imem[1] = enc_i('h09, 0, 4, 1);
    m_imem[2] = enc_j('h03, 6);
    m_imem[3] = enc_r(3, 4, 2, 'h2A);
    m_imem[6] = enc_r(31, 0, 0, 'h08);
    applyStimulus("jal_jr");

    // Illegal opcode at pc 2.
    fill_halt();
    m_imem[0] = enc_i('h09, 0, 2, 9);
    m_imem[1] = enc_i('h09, 2, 2, 1);
    m_imem[2] = enc_j('h3F, 0);
    applyStimulus("badop");

    for (int t = 0; t < 20; t++) begin
      random_program();
      applyStimulus($sformatf("rand%0d", t));
    end

    repeat (2) @(negedge clk);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
